// File: rtl/apb_requester.sv
// APB requester: one host command at a time -> APB setup/access -> valid/ready response.
// Optional ACCESS wait-state timeout enabled by defining APB_TIMEOUT_EN.
module apb_requester #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    // state  | meaning
    // IDLE   | waiting for a host command (cmd_ready=1)
    // SETUP  | APB setup phase, PSEL=1 PENABLE=0
    // ACCESS | APB access phase, waits for PREADY
    // RESP   | response held until the host takes it
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state, state_nxt;
    logic                psel_nxt, penable_nxt, pwrite_nxt, rsp_valid_nxt;
    logic [ADDR_W-1:0]   paddr_nxt;
    logic [DATA_W-1:0]   pwdata_nxt, rsp_rdata_nxt;

`ifdef APB_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic        rsp_err_nxt;
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES > 0);
    assign rsp_err        = 1'b0;
`endif

    assign cmd_ready = (state == IDLE);

    always_comb begin
        state_nxt     = state;
        psel_nxt      = PSEL;
        penable_nxt   = PENABLE;
        pwrite_nxt    = PWRITE;
        paddr_nxt     = PADDR;
        pwdata_nxt    = PWDATA;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
`ifdef APB_TIMEOUT_EN
        wait_cnt_nxt  = wait_cnt;
        rsp_err_nxt   = rsp_err;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_nxt = cmd_write;
                    paddr_nxt  = cmd_addr;
                    pwdata_nxt = cmd_wdata;
                    psel_nxt   = 1'b1;
                    state_nxt  = SETUP;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                state_nxt   = ACCESS;
`ifdef APB_TIMEOUT_EN
                wait_cnt_nxt = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_rdata_nxt = PWRITE ? '0 : PRDATA;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
`ifdef APB_TIMEOUT_EN
                    rsp_err_nxt   = 1'b0;
                end else if (wait_cnt == TO_LIMIT) begin
                    // completer never answered: abort with an error response
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else begin
                    wait_cnt_nxt  = wait_cnt + 16'd1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
            wait_cnt  <= '0;
            rsp_err   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            PSEL      <= psel_nxt;
            PENABLE   <= penable_nxt;
            PWRITE    <= pwrite_nxt;
            PADDR     <= paddr_nxt;
            PWDATA    <= pwdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
`ifdef APB_TIMEOUT_EN
            wait_cnt  <= wait_cnt_nxt;
            rsp_err   <= rsp_err_nxt;
`endif
        end
    end

endmodule
